// File: rtl/scr1_tcm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scr1_tcm_ctrl_pkg
// Desc     : Shared types and byte-merge helper for the TCM port B controller.
// Revision : 1.0
// ============================================================================
package scr1_tcm_ctrl_pkg;

    typedef enum logic [1:0] {
        SCR1_TCM_FSM_IDLE  = 2'd0,
        SCR1_TCM_FSM_MERGE = 2'd1,
        SCR1_TCM_FSM_RESP  = 2'd2
    } type_scr1_tcm_ctrl_fsm_e;

    typedef enum logic [0:0] {
        SCR1_TCM_REQ_CORE = 1'b0,
        SCR1_TCM_REQ_LDR  = 1'b1
    } type_scr1_tcm_req_e;

    localparam int unsigned C_BYTE_W = 8;

    function automatic logic [C_BYTE_W-1:0] scr1_tcm_be_merge(
        input logic [C_BYTE_W-1:0] old_byte,
        input logic [C_BYTE_W-1:0] new_byte,
        input logic                be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage : scr1_tcm_ctrl_pkg
`default_nettype wire

// File: rtl/scr1_tcm_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : scr1_tcm_rr_arb2
// Desc     : Two-input round-robin arbiter; bit 0 = CORE, bit 1 = LDR.
// Revision : 1.0
// ============================================================================
module scr1_tcm_rr_arb2
    import scr1_tcm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    type_scr1_tcm_req_e last_grant_q;
    type_scr1_tcm_req_e last_grant_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (last_grant_q == SCR1_TCM_REQ_LDR) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (i_advance && o_gnt[1]) begin
            last_grant_d = SCR1_TCM_REQ_LDR;
        end else if (i_advance && o_gnt[0]) begin
            last_grant_d = SCR1_TCM_REQ_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= SCR1_TCM_REQ_LDR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : scr1_tcm_rr_arb2
`default_nettype wire

// File: rtl/scr1_tcm_portb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scr1_tcm_portb_ctrl
// Desc     : TCM port B sequencer: CORE/LDR round-robin sharing, optional RMW.
// Revision : 1.0
// ============================================================================
module scr1_tcm_portb_ctrl
    import scr1_tcm_ctrl_pkg::*;
#(
    parameter int unsigned SCR1_WIDTH  = 32,
    parameter int unsigned SCR1_SIZE   = 32'h00010000,
    parameter int unsigned SCR1_NBYTES = SCR1_WIDTH / 8,
    parameter bit          RMW_EN      = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         core_req,
    input  logic                         core_we,
    input  logic [SCR1_NBYTES-1:0]       core_be,
    input  logic [$clog2(SCR1_SIZE)-1:2] core_addr,
    input  logic [SCR1_WIDTH-1:0]        core_wdata,
    output logic                         core_ack,
    output logic [SCR1_WIDTH-1:0]        core_rdata,
    input  logic                         ldr_req,
    input  logic                         ldr_we,
    input  logic [SCR1_NBYTES-1:0]       ldr_be,
    input  logic [$clog2(SCR1_SIZE)-1:2] ldr_addr,
    input  logic [SCR1_WIDTH-1:0]        ldr_wdata,
    output logic                         ldr_ack,
    output logic [SCR1_WIDTH-1:0]        ldr_rdata,
    output logic                         renb,
    output logic                         wenb,
    output logic [SCR1_NBYTES-1:0]       webb,
    output logic [$clog2(SCR1_SIZE)-1:2] addrb,
    output logic [SCR1_WIDTH-1:0]        datab,
    input  logic [SCR1_WIDTH-1:0]        qb
);

    localparam int unsigned C_AW = $clog2(SCR1_SIZE);

    type_scr1_tcm_ctrl_fsm_e state_q,   state_d;
    type_scr1_tcm_req_e      owner_q,   owner_d;
    logic                    we_q,      we_d;
    logic [SCR1_NBYTES-1:0]  be_q,      be_d;
    logic [C_AW-1:2]         addr_q,    addr_d;
    logic [SCR1_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [SCR1_WIDTH-1:0]   core_rdata_q, core_rdata_d;
    logic [SCR1_WIDTH-1:0]   ldr_rdata_q,  ldr_rdata_d;

    logic [1:0]              w_gnt;
    logic                    w_advance;
    logic                    w_sel_we;
    logic [SCR1_NBYTES-1:0]  w_sel_be;
    logic [C_AW-1:2]         w_sel_addr;
    logic [SCR1_WIDTH-1:0]   w_sel_wdata;
    logic                    w_sel_rmw;
    logic [SCR1_WIDTH-1:0]   w_merged;

    assign w_advance = rst_n && (state_q == SCR1_TCM_FSM_IDLE);

    scr1_tcm_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     ({ldr_req, core_req}),
        .i_advance (w_advance),
        .o_gnt     (w_gnt)
    );

    assign w_sel_we    = w_gnt[1] ? ldr_we    : core_we;
    assign w_sel_be    = w_gnt[1] ? ldr_be    : core_be;
    assign w_sel_addr  = w_gnt[1] ? ldr_addr  : core_addr;
    assign w_sel_wdata = w_gnt[1] ? ldr_wdata : core_wdata;
    assign w_sel_rmw   = RMW_EN && (|w_sel_be) && !(&w_sel_be);

    for (genvar i = 0; i < SCR1_NBYTES; i++) begin : g_lane
        assign w_merged[i*8 +: 8] = scr1_tcm_be_merge(qb[i*8 +: 8], wdata_q[i*8 +: 8], be_q[i]);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rdata_d = core_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        renb         = 1'b0;
        wenb         = 1'b0;
        webb         = '0;
        addrb        = '0;
        datab        = '0;
        core_ack     = 1'b0;
        ldr_ack      = 1'b0;
        core_rdata   = core_rdata_q;
        ldr_rdata    = ldr_rdata_q;
        case (state_q)
            SCR1_TCM_FSM_IDLE: begin
                if (|w_gnt) begin
                    owner_d = w_gnt[1] ? SCR1_TCM_REQ_LDR : SCR1_TCM_REQ_CORE;
                    we_d    = w_sel_we;
                    be_d    = w_sel_be;
                    addr_d  = w_sel_addr;
                    wdata_d = w_sel_wdata;
                    state_d = SCR1_TCM_FSM_RESP;
                    if (!w_sel_we) begin
                        renb  = 1'b1;
                        addrb = w_sel_addr;
                    end else if (w_sel_be == '0) begin
                        state_d = SCR1_TCM_FSM_RESP;
                    end else if (w_sel_rmw) begin
                        renb    = 1'b1;
                        addrb   = w_sel_addr;
                        state_d = SCR1_TCM_FSM_MERGE;
                    end else begin
                        wenb  = 1'b1;
                        webb  = w_sel_be;
                        addrb = w_sel_addr;
                        datab = w_sel_wdata;
                    end
                end
            end
            SCR1_TCM_FSM_MERGE: begin
                wenb    = 1'b1;
                webb    = {SCR1_NBYTES{1'b1}};
                addrb   = addr_q;
                datab   = w_merged;
                state_d = SCR1_TCM_FSM_RESP;
            end
            SCR1_TCM_FSM_RESP: begin
                state_d = SCR1_TCM_FSM_IDLE;
                if (owner_q == SCR1_TCM_REQ_LDR) begin
                    ldr_ack = 1'b1;
                    if (!we_q) begin
                        ldr_rdata_d = qb;
                        ldr_rdata   = qb;
                    end
                end else begin
                    core_ack = 1'b1;
                    if (!we_q) begin
                        core_rdata_d = qb;
                        core_rdata   = qb;
                    end
                end
            end
            default: state_d = SCR1_TCM_FSM_IDLE;
        endcase
        // While reset is held nothing reaches the memory or the requesters;
        // this is also what drops an in-flight MERGE write.
        if (!rst_n) begin
            renb       = 1'b0;
            wenb       = 1'b0;
            webb       = '0;
            addrb      = '0;
            datab      = '0;
            core_ack   = 1'b0;
            ldr_ack    = 1'b0;
            core_rdata = '0;
            ldr_rdata  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SCR1_TCM_FSM_IDLE;
            owner_q      <= SCR1_TCM_REQ_CORE;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rdata_q <= core_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

`ifndef SYNTHESIS
    // A pending requester must hold req and all fields until its ack.
    a_core_hold: assert property (@(posedge clk)
        (rst_n && core_req && !core_ack) |=>
        (!rst_n || (core_req && $stable({core_we, core_be, core_addr, core_wdata}))));
    a_ldr_hold: assert property (@(posedge clk)
        (rst_n && ldr_req && !ldr_ack) |=>
        (!rst_n || (ldr_req && $stable({ldr_we, ldr_be, ldr_addr, ldr_wdata}))));
`endif

endmodule : scr1_tcm_portb_ctrl
`default_nettype wire

// File: tb/tb_scr1_tcm_portb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr1_tcm_portb_ctrl
// Desc     : Self-checking bench: word-level memory reference vs. port B traffic.
// Revision : 1.0
// ============================================================================
module tb_scr1_tcm_portb_ctrl;

    localparam int unsigned C_WORDS = 16384;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we, core_ack, ldr_req, ldr_we, ldr_ack;
    logic [3:0]  core_be, ldr_be, webb;
    logic [13:0] core_addr, ldr_addr, addrb;
    logic [31:0] core_wdata, ldr_wdata, core_rdata, ldr_rdata, datab, qb;
    logic        renb, wenb;

    logic        core0_req, core0_we, core0_ack, ldr0_ack, renb0, wenb0;
    logic [3:0]  core0_be, webb0;
    logic [13:0] core0_addr, addrb0;
    logic [31:0] core0_wdata, core0_rdata, ldr0_rdata, datab0, qb0;

    logic [31:0] mem     [C_WORDS];
    logic [31:0] ref_mem [C_WORDS];
    int          n_err;
    int          n_chk;
    bit          last_ldr;

    logic        a_we    [2];
    logic [3:0]  a_be    [2];
    logic [13:0] a_addr  [2];
    logic [31:0] a_wdata [2];
    int          done_n  [2];

    assign qb0 = '0;

    scr1_tcm_portb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb)
    );

    scr1_tcm_portb_ctrl #(.RMW_EN(1'b0)) dut_nrmw (
        .clk(clk), .rst_n(rst_n),
        .core_req(core0_req), .core_we(core0_we), .core_be(core0_be), .core_addr(core0_addr),
        .core_wdata(core0_wdata), .core_ack(core0_ack), .core_rdata(core0_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_be(4'h0), .ldr_addr(14'h0),
        .ldr_wdata(32'h0), .ldr_ack(ldr0_ack), .ldr_rdata(ldr0_rdata),
        .renb(renb0), .wenb(wenb0), .webb(webb0), .addrb(addrb0), .datab(datab0), .qb(qb0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        if (i == 48) return 32'hAABBCCDD;
        return (32'(i) * 32'h9E3779B9) ^ 32'h0F0F1234;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return r;
    endfunction

    function automatic int lat_of(input logic we, input logic [3:0] be);
        return (we && be != 4'h0 && be != 4'hF) ? 2 : 1;
    endfunction

    function automatic logic [3:0] rand_be();
        case ($urandom_range(0, 3))
            0:       return 4'h0;
            1:       return 4'hF;
            default: return 4'($urandom);
        endcase
    endfunction

    // Synchronous RAM with a registered read port and byte-lane writes.
    initial begin
        qb = '0;
        for (int i = 0; i < C_WORDS; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (renb) qb <= mem[addrb];
            if (wenb) for (int b = 0; b < 4; b++) if (webb[b]) mem[addrb][b*8 +: 8] <= datab[b*8 +: 8];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit who, input logic on, input logic we, input logic [3:0] be,
                           input logic [13:0] addr, input logic [31:0] wdata);
        if (who) begin
            ldr_req = on; ldr_we = we; ldr_be = be; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            core_req = on; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
        end
    endtask

    task automatic new_fields(input int r);
        a_we[r]    = 1'($urandom);
        a_be[r]    = rand_be();
        a_addr[r]  = 14'($urandom_range(0, 63));
        a_wdata[r] = $urandom;
    endtask

    // One transaction from a single requester, checked cycle by cycle.
    task automatic run_txn(input bit who, input logic we, input logic [3:0] be,
                           input logic [13:0] addr, input logic [31:0] wdata,
                           output logic [31:0] obs_rdata);
        int          lat;
        int          cyc;
        bit          done;
        bit          partial;
        logic [31:0] merged;
        partial   = we && be != 4'h0 && be != 4'hF;
        lat       = lat_of(we, be);
        merged    = ref_merge(ref_mem[addr], wdata, be);
        obs_rdata = '0;
        set_req(who, 1'b1, we, be, addr, wdata);
        cyc  = 0;
        done = 0;
        while (!done && cyc < 6) begin
            @(negedge clk);
            if ((who ? ldr_ack : core_ack) == 1'b1) begin
                chk("ack_latency", 64'(cyc), 64'(lat));
                chk("ack_other", who ? core_ack : ldr_ack, 0);
                chk("ack_no_mem", {renb, wenb}, 0);
                if (!we) begin
                    obs_rdata = who ? ldr_rdata : core_rdata;
                    chk("rdata", obs_rdata, ref_mem[addr]);
                end else begin
                    ref_mem[addr] = merged;
                end
                last_ldr = who;
                done     = 1;
            end else if (cyc == 0) begin
                if (!we)               chk("c0_read", {renb, wenb, addrb}, {2'b10, addr});
                else if (be == 4'h0)   chk("c0_be0", {renb, wenb}, 0);
                else if (partial)      chk("c0_rmw_read", {renb, wenb, addrb}, {2'b10, addr});
                else                   chk("c0_write", {renb, wenb, webb, addrb, datab},
                                           {2'b01, be, addr, wdata});
            end else if (cyc == 1 && partial) begin
                chk("c1_merge", {renb, wenb, webb, addrb, datab}, {2'b01, 4'hF, addr, merged});
            end
            cyc++;
            if (!done) begin @(posedge clk); #1; end
        end
        if (!done) chk("ack_timeout", 0, 1);
        @(posedge clk); #1;
        set_req(who, 1'b0, we, be, addr, wdata);
    endtask

    initial begin
        logic [31:0] rd;
        int          exp_who;
        int          got;
        int          cyc;
        int          bad;
        logic [31:0] wd;
        n_err = 0; n_chk = 0; last_ldr = 1'b1;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        core0_req = 1'b0; core0_we = 1'b0; core0_be = 4'h0; core0_addr = '0; core0_wdata = '0;
        for (int i = 0; i < C_WORDS; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_mem_if", {renb, wenb, webb, addrb, datab}, 0);
        chk("reset_acks", {core_ack, ldr_ack, core0_ack, renb0, wenb0}, 0);
        chk("reset_rdata", {core_rdata, ldr_rdata}, 0);
        @(posedge clk); #1;

        run_txn(1'b0, 1'b0, 4'h0, 14'h10, 32'h0, rd);
        chk("read_0x10", rd, 32'hDEADBEEF);
        run_txn(1'b0, 1'b1, 4'hF, 14'h20, 32'h12345678, rd);
        run_txn(1'b0, 1'b0, 4'h0, 14'h20, 32'h0, rd);
        chk("read_0x20", rd, 32'h12345678);
        run_txn(1'b0, 1'b1, 4'b0101, 14'h30, 32'h11223344, rd);
        run_txn(1'b1, 1'b0, 4'h0, 14'h30, 32'h0, rd);
        chk("rmw_readback", rd, 32'hAA22CC44);
        run_txn(1'b1, 1'b1, 4'h0, 14'h21, 32'hFFFF_FFFF, rd);

        for (int k = 0; k < 16; k++)
            run_txn(1'($urandom), 1'($urandom), rand_be(), 14'($urandom_range(0, 63)), $urandom, rd);

        // Both requesters held for four transactions each.
        for (int r = 0; r < 2; r++) begin
            new_fields(r);
            done_n[r] = 0;
            set_req(r[0], 1'b1, a_we[r], a_be[r], a_addr[r], a_wdata[r]);
        end
        for (int k = 0; k < 8; k++) begin
            if (done_n[0] < 4 && done_n[1] < 4) exp_who = last_ldr ? 0 : 1;
            else                                exp_who = (done_n[0] < 4) ? 0 : 1;
            got = -1;
            cyc = 0;
            while (got < 0 && cyc < 6) begin
                @(negedge clk);
                if (core_ack || ldr_ack) begin
                    got = ldr_ack ? 1 : 0;
                    chk("arb_grant", {core_ack, ldr_ack}, (exp_who == 1) ? 2'b01 : 2'b10);
                    chk("arb_latency", 64'(cyc), 64'(lat_of(a_we[got], a_be[got])));
                    if (!a_we[got]) chk("arb_rdata", (got == 1) ? ldr_rdata : core_rdata,
                                        ref_mem[a_addr[got]]);
                    else ref_mem[a_addr[got]] = ref_merge(ref_mem[a_addr[got]], a_wdata[got], a_be[got]);
                end
                cyc++;
                @(posedge clk); #1;
            end
            if (got < 0) begin
                chk("arb_timeout", 0, 1);
                break;
            end
            last_ldr = (got == 1);
            done_n[got]++;
            if (done_n[got] < 4) new_fields(got);
            set_req(got[0], done_n[got] < 4, a_we[got], a_be[got], a_addr[got], a_wdata[got]);
        end
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        @(posedge clk); #1;

        // Reset during MERGE drops the write and clears the arbiter history.
        wd = $urandom;
        set_req(1'b0, 1'b1, 1'b1, 4'b0101, 14'h31, wd);
        @(negedge clk);
        chk("rst_c0_renb", {renb, wenb}, 2'b10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req(1'b1, 1'b1, 1'b0, 4'h0, 14'h32, 32'h0);
        @(negedge clk);
        chk("rst_merge_wenb", {renb, wenb}, 0);
        chk("rst_merge_ack", {core_ack, ldr_ack}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_idle_quiet", {renb, wenb, core_ack, ldr_ack}, 0);
        chk("rst_rdata_zero", {core_rdata, ldr_rdata}, 0);
        chk("rst_write_dropped", mem[14'h31], ref_mem[14'h31]);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        last_ldr = 1'b1;
        @(negedge clk);
        chk("rst_first_tie_core", {renb, wenb, addrb}, {2'b10, 14'h31});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rerun_merge", {wenb, datab}, {1'b1, ref_merge(ref_mem[14'h31], wd, 4'b0101)});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rerun_ack", {core_ack, ldr_ack}, 2'b10);
        ref_mem[14'h31] = ref_merge(ref_mem[14'h31], wd, 4'b0101);
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk);
        chk("rst_ldr_next", {renb, addrb}, {1'b1, 14'h32});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ldr_ack", {core_ack, ldr_ack, ldr_rdata}, {2'b01, ref_mem[14'h32]});
        @(posedge clk); #1;
        ldr_req = 1'b0;

        // Byte enables passed straight through when RMW is disabled.
        wd = $urandom;
        core0_req = 1'b1; core0_we = 1'b1; core0_be = 4'b0011; core0_addr = 14'h5; core0_wdata = wd;
        @(negedge clk);
        chk("nrmw_c0_write", {renb0, wenb0, webb0, addrb0, datab0}, {2'b01, 4'b0011, 14'h5, wd});
        chk("nrmw_c0_ack", core0_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nrmw_c1_ack", {core0_ack, renb0, wenb0}, 3'b100);
        @(posedge clk); #1;
        core0_be = 4'h0;
        @(negedge clk);
        chk("nrmw_be0_c0", {core0_ack, renb0, wenb0}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nrmw_be0_c1", {core0_ack, renb0, wenb0}, 3'b100);
        @(posedge clk); #1;
        core0_req = 1'b0;

        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", 64'(bad), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_scr1_tcm_portb_ctrl
`default_nettype wire
